// File: rtl/voice_scheduler.sv
// Sequences NUM_VOICES voices per sample tick over one shared multiplier/divider and mixes their outputs.
// Frame is >= 2*NUM_VOICES+2 cycles; ticks arriving outside IDLE are dropped and flagged as overrun.
module voice_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int TIMEOUT    = 1023,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_tick,
    output logic [NUM_VOICES-1:0]    voice_start,
    input  logic [NUM_VOICES-1:0]    voice_finish,
    input  logic [NUM_VOICES*32-1:0] voice_mult_a,
    input  logic [NUM_VOICES*32-1:0] voice_mult_b,
    input  logic [NUM_VOICES*48-1:0] voice_div_n,
    input  logic [NUM_VOICES*48-1:0] voice_div_d,
    input  logic [NUM_VOICES*24-1:0] voice_wave,
    output logic [31:0]              mult_a,
    output logic [31:0]              mult_b,
    output logic [47:0]              div_n,
    output logic [47:0]              div_d,
    output logic [23:0]              mix_out,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic [NUM_VOICES-1:0]    timeout_err
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = 24 + $clog2(NUM_VOICES) + 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [WD_W-1:0]         WD_MAX   = WD_W'(TIMEOUT);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(24'h7F_FFFF);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WD_W-1:0]          wdog_q, wdog_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [23:0]              mix_out_q, mix_out_d;
    logic                     mix_valid_q, mix_valid_d;
    logic                     overrun_q, overrun_d;
    logic [NUM_VOICES-1:0]    terr_q, terr_d;

    logic [NUM_VOICES-1:0]    idx_oh;
    logic                     sel_fin;
    logic signed [23:0]       sel_wave;
    logic [31:0]              sel_ma, sel_mb;
    logic [47:0]              sel_dn, sel_dd;
    logic signed [ACC_W-1:0]  wave_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic                     advance;

    // Granted-voice select; loop form keeps non-power-of-two voice counts in range.
    always_comb begin
        idx_oh   = '0;
        sel_fin  = 1'b0;
        sel_wave = '0;
        sel_ma   = '0;
        sel_mb   = '0;
        sel_dn   = '0;
        sel_dd   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                idx_oh[i] = 1'b1;
                sel_fin   = voice_finish[i];
                sel_wave  = voice_wave[i*24 +: 24];
                sel_ma    = voice_mult_a[i*32 +: 32];
                sel_mb    = voice_mult_b[i*32 +: 32];
                sel_dn    = voice_div_n[i*48 +: 48];
                sel_dd    = voice_div_d[i*48 +: 48];
            end
        end
    end

    assign wave_ext = {{(ACC_W-24){sel_wave[23]}}, sel_wave};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wdog_d      = wdog_q;
        acc_d       = acc_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;
        terr_d      = terr_q;
        voice_start = '0;
        mult_a      = '0;
        mult_b      = '0;
        div_n       = '0;
        div_d       = '0;
        advance     = 1'b0;
        shifted     = '0;

        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                voice_start = idx_oh;
                mult_a      = sel_ma;
                mult_b      = sel_mb;
                div_n       = sel_dn;
                div_d       = sel_dd;
                wdog_d      = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                mult_a = sel_ma;
                mult_b = sel_mb;
                div_n  = sel_dn;
                div_d  = sel_dd;
                // Finish is checked before the deadline so a same-cycle finish is never flagged.
                if (sel_fin) begin
                    acc_d   = acc_q + wave_ext;
                    advance = 1'b1;
                end else if (wdog_q == WD_MAX) begin
                    terr_d  = terr_q | idx_oh;
                    advance = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The mix is registered on the last advance so it is presented during DONE.
        shifted = acc_d >>> MIX_SHIFT;
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d     = S_DONE;
                mix_valid_d = 1'b1;
                if (shifted > SAT_MAX) begin
                    mix_out_d = 24'h7F_FFFF;
                end else if (shifted < SAT_MIN) begin
                    mix_out_d = 24'h80_0000;
                end else begin
                    mix_out_d = shifted[23:0];
                end
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_START;
            end
        end

        if (sample_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wdog_q      <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            terr_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wdog_q      <= wdog_d;
            acc_q       <= acc_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
            terr_q      <= terr_d;
        end
    end

    assign mix_out     = mix_out_q;
    assign mix_valid   = mix_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: two instances (MIX_SHIFT 2 and 0) share one set of modelled voices.
module tb_voice_scheduler;

    localparam int N  = 8;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic            rst_s;
    logic            sample_tick;
    logic [N-1:0]    voice_finish;
    logic [N*32-1:0] voice_mult_a, voice_mult_b;
    logic [N*48-1:0] voice_div_n, voice_div_d;
    logic [N*24-1:0] voice_wave;

    logic [N-1:0] a_voice_start, z_voice_start;
    logic [31:0]  a_mult_a, a_mult_b, z_mult_a, z_mult_b;
    logic [47:0]  a_div_n, a_div_d, z_div_n, z_div_d;
    logic [23:0]  a_mix_out, z_mix_out;
    logic         a_mix_valid, z_mix_valid, a_busy, z_busy, a_overrun, z_overrun;
    logic [N-1:0] a_terr, z_terr;

    voice_scheduler #(.NUM_VOICES(N), .TIMEOUT(TO), .MIX_SHIFT(2)) u_dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .voice_start(a_voice_start), .voice_finish(voice_finish),
        .voice_mult_a(voice_mult_a), .voice_mult_b(voice_mult_b),
        .voice_div_n(voice_div_n), .voice_div_d(voice_div_d), .voice_wave(voice_wave),
        .mult_a(a_mult_a), .mult_b(a_mult_b), .div_n(a_div_n), .div_d(a_div_d),
        .mix_out(a_mix_out), .mix_valid(a_mix_valid), .busy(a_busy),
        .overrun(a_overrun), .timeout_err(a_terr)
    );

    voice_scheduler #(.NUM_VOICES(N), .TIMEOUT(TO), .MIX_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .voice_start(z_voice_start), .voice_finish(voice_finish),
        .voice_mult_a(voice_mult_a), .voice_mult_b(voice_mult_b),
        .voice_div_n(voice_div_n), .voice_div_d(voice_div_d), .voice_wave(voice_wave),
        .mult_a(z_mult_a), .mult_b(z_mult_b), .div_n(z_div_n), .div_d(z_div_d),
        .mix_out(z_mix_out), .mix_valid(z_mix_valid), .busy(z_busy),
        .overrun(z_overrun), .timeout_err(z_terr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] exp_ops(input int g);
        if (g < 0) return '0;
        return {32'(g + 1), 32'(100 + g), 48'h1_0000_0000 + 48'(g), 48'(g + 7)};
    endfunction

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Voice model and grant/operand monitor, evaluated mid-cycle.
    int           dly [N];
    int           cnt [N];
    int           grant = -1;
    int           wcnt  = 0;
    int           nxt   = 0;
    logic [N-1:0] fin;

    always @(posedge clk) rst_s <= rst;

    always @(negedge clk) begin
        fin = '0;
        if (rst_s) begin
            for (int i = 0; i < N; i++) cnt[i] = 0;
            grant = -1;
            wcnt  = 0;
            nxt   = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) fin[i] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) if (a_voice_start[i]) cnt[i] = dly[i];
            if (a_voice_start != '0) begin
                chk("start_order", 160'(a_voice_start), 160'(oh(nxt)));
                grant = nxt;
                nxt   = (nxt + 1) % N;
                wcnt  = 0;
                chk("ops_start", {a_mult_a, a_mult_b, a_div_n, a_div_d}, exp_ops(grant));
            end else if (grant >= 0) begin
                chk("ops_wait", {a_mult_a, a_mult_b, a_div_n, a_div_d}, exp_ops(grant));
                if (fin[grant] || wcnt == TO) grant = -1;
                else wcnt++;
            end else begin
                chk("ops_idle", {a_mult_a, a_mult_b, a_div_n, a_div_d}, exp_ops(-1));
            end
        end
        voice_finish = fin;
    end

    task automatic set_waves(input int mode, input logic [23:0] val, input int slow);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       voice_wave[i*24 +: 24] = 24'(1000 * (i + 1));
                1:       voice_wave[i*24 +: 24] = val;
                default: voice_wave[i*24 +: 24] = (i == 0) ? val : 24'd0;
            endcase
            dly[i] = (i == slow) ? 30 : 5;
        end
    endtask

    task automatic run_frame(input int ovr_at, input bit done_tick,
                             output int nv, output logic [23:0] m2, output logic [23:0] m0);
        int inj;
        inj = -1;
        nv  = 0;
        m2  = '0;
        m0  = '0;
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        chk("first_start", 160'(a_voice_start), 160'(1));
        chk("busy_hi", 160'(a_busy), 160'(1));
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (a_mix_valid) begin
                nv++;
                m2 = a_mix_out;
                m0 = z_mix_out;
                if (done_tick) sample_tick = 1'b1;
            end
            if (inj > 0) begin
                inj--;
                if (inj == 0) sample_tick = 1'b1;
            end
            if (ovr_at >= 0 && a_voice_start == oh(ovr_at)) inj = 2;
        end
        sample_tick = 1'b0;
        chk("busy_lo", 160'(a_busy), 160'(0));
    endtask

    typedef struct {
        int          mode;
        logic [23:0] val;
        int          slow;
        logic [23:0] exp2;
        logic [23:0] exp0;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t        vt [6];
    int          nv;
    logic [23:0] m2, m0;
    bit          found;

    initial begin
        vt[0] = '{0, 24'd0,       -1, 24'd9000,    24'd36000,   8'h00};
        vt[1] = '{1, 24'h7F_FFFF, -1, 24'h7F_FFFF, 24'h7F_FFFF, 8'h00};
        vt[2] = '{1, 24'h80_0000, -1, 24'h80_0000, 24'h80_0000, 8'h00};
        vt[3] = '{2, 24'hFF_FFFF, -1, 24'hFF_FFFF, 24'hFF_FFFF, 8'h00};
        vt[4] = '{1, 24'hFF_FFFB, -1, 24'hFF_FFF6, 24'hFF_FFD8, 8'h00};
        vt[5] = '{0, 24'd0,        3, 24'd8000,    24'd32000,   8'h08};

        rst         = 1'b1;
        sample_tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            voice_mult_a[i*32 +: 32] = 32'(i + 1);
            voice_mult_b[i*32 +: 32] = 32'(100 + i);
            voice_div_n[i*48 +: 48]  = 48'h1_0000_0000 + 48'(i);
            voice_div_d[i*48 +: 48]  = 48'(i + 7);
        end
        set_waves(0, 24'd0, -1);

        repeat (3) @(negedge clk);
        chk("rst_start", 160'(a_voice_start), 160'(0));
        chk("rst_ops", {a_mult_a, a_mult_b, a_div_n, a_div_d}, 160'(0));
        chk("rst_mix", 160'({a_mix_out, z_mix_out}), 160'(0));
        chk("rst_flags", 160'({a_mix_valid, a_busy, a_overrun, a_terr}), 160'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            set_waves(vt[v].mode, vt[v].val, vt[v].slow);
            run_frame(-1, 1'b0, nv, m2, m0);
            chk($sformatf("v%0d_nvalid", v), 160'(nv), 160'(1));
            chk($sformatf("v%0d_mix_sh2", v), 160'(m2), 160'(vt[v].exp2));
            chk($sformatf("v%0d_mix_sh0", v), 160'(m0), 160'(vt[v].exp0));
            chk($sformatf("v%0d_terr", v), 160'(a_terr), 160'(vt[v].exp_err));
            chk($sformatf("v%0d_overrun", v), 160'(a_overrun), 160'(0));
        end

        // Extra tick during voice 2's WAIT: dropped, flagged, frame unaffected.
        set_waves(0, 24'd0, -1);
        run_frame(2, 1'b0, nv, m2, m0);
        chk("ovr_flag", 160'(a_overrun), 160'(1));
        chk("ovr_nvalid", 160'(nv), 160'(1));
        chk("ovr_mix", 160'(m2), 160'(24'd9000));
        run_frame(-1, 1'b0, nv, m2, m0);
        chk("after_ovr_nvalid", 160'(nv), 160'(1));
        chk("after_ovr_mix", 160'(m2), 160'(24'd9000));

        // Reset during voice 1's WAIT abandons the frame.
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (a_voice_start == oh(1)) found = 1'b1;
        end
        chk("mid_rst_reach_v1", 160'(found), 160'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_start", 160'(a_voice_start), 160'(0));
        chk("mid_rst_ops", {a_mult_a, a_mult_b, a_div_n, a_div_d}, 160'(0));
        chk("mid_rst_mix", 160'(a_mix_out), 160'(0));
        chk("mid_rst_flags", 160'({a_mix_valid, a_busy, a_overrun, a_terr}), 160'(0));
        rst = 1'b0;
        nv  = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (a_mix_valid) nv++;
        end
        chk("mid_rst_no_valid", 160'(nv), 160'(0));
        run_frame(-1, 1'b0, nv, m2, m0);
        chk("post_rst_nvalid", 160'(nv), 160'(1));
        chk("post_rst_mix", 160'(m2), 160'(24'd9000));

        // Tick landing in the DONE cycle is dropped: no second frame, overrun set.
        run_frame(-1, 1'b1, nv, m2, m0);
        chk("done_tick_nvalid", 160'(nv), 160'(1));
        chk("done_tick_overrun", 160'(a_overrun), 160'(1));
        chk("done_tick_mix", 160'(m2), 160'(24'd9000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
